wb_region_router: RTL and testbench

- Parametrised, registered successor to the combinational physical-address decoder.
- Sits between the CPU-side Wishbone master (post-TLB physical address) and NSLV Wishbone slaves (RAM, ROM, flash, UART, digseg, PS/2, ...).
- Decodes the address against a parameter region table and forwards one transaction at a time to the matching slave.
- Returns data/ack, or raises a bus error on unmapped addresses or on slave timeout.

---
 rtl/wb_region_router.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_region_router.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_region_router.sv
// wb_region_router
//   Registered Wishbone address router. A single master request is decoded
//   against a table of NSLV (base, mask) regions and forwarded to the
//   matching slave. The router handles one transaction at a time. It returns
//   the slave's read data and ack to the master. It raises a bus error when
//   no region matches the address or when the selected slave does not ack
//   within TO_CYCLES cycles.
//
//   Optional build macro: WB_ROUTER_FAULT_CAPTURE_EN
//     When defined, the router adds a sticky fault capture register with
//     these ports: fault_clr_i, fault_o, fault_adr_o and fault_to_o.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   m_cyc_i/m_stb_i   master cycle / strobe
//   m_we_i, m_adr_i   master write enable and address
//   m_sel_i, m_dat_i  master byte selects and write data
//   m_dat_o           read data returned to the master
//   m_ack_o           one-cycle transaction-complete pulse
//   m_err_o           one-cycle bus-error pulse (unmapped or timeout)
//   s_cyc_o/s_stb_o   one-hot slave cycle / strobe
//   s_we_o, s_adr_o   shared slave write enable and address
//   s_sel_o, s_dat_o  shared slave byte selects and write data
//   s_dat_i           packed slave read data, slot i at [i*DW +: DW]
//   s_ack_i           per-slave acks
//   fault_clr_i       (macro) clears the sticky fault flag
//   fault_o           (macro) sticky fault flag
//   fault_adr_o       (macro) address of the first captured fault
//   fault_to_o        (macro) cause of the captured fault: 1 timeout, 0 unmapped
//
// Handshake: the master holds m_cyc_i/m_stb_i until it sees m_ack_o or
// m_err_o. Slaves see s_cyc_o/s_stb_o high until they return s_ack_i. An
// ack is only honoured from the slave that is currently selected. Dropping
// m_cyc_i while the router is in ACCESS abandons the transaction silently.
module wb_region_router #(
    parameter int NSLV = 8,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {
        32'h2000_0000, 32'h1FF0_0000, 32'h1FD0_0300, 32'h1FE0_0000,
        32'h1E00_0000, 32'h1FD0_0000, 32'h1FC0_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {
        32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000,
        32'hFF00_0000, 32'hFFFF_0000, 32'hFFF0_0000, 32'hFF80_0000},
    parameter int TO_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_cyc_i,
    input  logic               m_stb_i,
    input  logic               m_we_i,
    input  logic [AW-1:0]      m_adr_i,
    input  logic [DW/8-1:0]    m_sel_i,
    input  logic [DW-1:0]      m_dat_i,
    output logic [DW-1:0]      m_dat_o,
    output logic               m_ack_o,
    output logic               m_err_o,
    output logic [NSLV-1:0]    s_cyc_o,
    output logic [NSLV-1:0]    s_stb_o,
    output logic               s_we_o,
    output logic [AW-1:0]      s_adr_o,
    output logic [DW/8-1:0]    s_sel_o,
    output logic [DW-1:0]      s_dat_o,
    input  logic [NSLV*DW-1:0] s_dat_i,
    input  logic [NSLV-1:0]    s_ack_i
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
    ,
    input  logic               fault_clr_i,
    output logic               fault_o,
    output logic [AW-1:0]      fault_adr_o,
    output logic               fault_to_o
`endif
);

    localparam int CW = $clog2(TO_CYCLES + 1);
    // Timeout fires in the ACCESS cycle where the counter would reach
    // TO_CYCLES. This gives the slave exactly TO_CYCLES strobe cycles.
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] hit_q;
    logic [DW-1:0]   rdata;
    logic            sel_ack;
    logic [CW-1:0]   cnt;
    logic            take_req;

    assign take_req = (state == IDLE) && m_cyc_i && m_stb_i;

    // Parallel region compare. The loop runs from the highest index down, so
    // the lowest matching slot is the last one written and wins.
    always_comb begin
        hit = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_adr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    // hit_q is one-hot, so an AND-OR mux is enough for the return path.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (hit_q[i]) begin
                rdata = rdata | s_dat_i[i*DW +: DW];
            end
        end
    end

    assign sel_ack = |(s_ack_i & hit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        m_ack_o    = 1'b0;
        m_err_o    = 1'b0;
        s_cyc_o    = '0;
        s_stb_o    = '0;
        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    state_next = (|hit) ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                s_cyc_o = hit_q;
                s_stb_o = hit_q;
                // Abort beats ack and timeout. An ack that arrives in the same
                // cycle as the timeout still completes the transfer.
                if (!m_cyc_i) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    state_next = RESP;
                end else if (cnt == TO_LAST) begin
                    state_next = ERR;
                end
            end
            RESP: begin
                m_ack_o    = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                m_err_o    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            s_we_o  <= 1'b0;
            hit_q   <= '0;
            cnt     <= '0;
            m_dat_o <= '0;
        end else begin
            if (take_req) begin
                s_adr_o <= m_adr_i;
                s_dat_o <= m_dat_i;
                s_sel_o <= m_sel_i;
                s_we_o  <= m_we_i;
                hit_q   <= hit;
            end
            // The counter runs only while the router stays in ACCESS. It is
            // zero on every entry to ACCESS.
            if ((state == ACCESS) && (state_next == ACCESS)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if ((state == ACCESS) && (state_next == RESP)) begin
                m_dat_o <= rdata;
            end else if ((state != ERR) && (state_next == ERR)) begin
                m_dat_o <= '0;
            end
        end
    end

`ifdef WB_ROUTER_FAULT_CAPTURE_EN
    logic          fault_q;
    logic [AW-1:0] fault_adr_q;
    logic          fault_to_q;
    logic          err_entry;

    assign err_entry = (state != ERR) && (state_next == ERR);

    // A clear in the same cycle as a new fault frees the register, so the new
    // fault is captured. An unmapped fault is detected in IDLE, before the
    // address reaches s_adr_o, so its address is taken from m_adr_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q     <= 1'b0;
            fault_adr_q <= '0;
            fault_to_q  <= 1'b0;
        end else if (err_entry && (!fault_q || fault_clr_i)) begin
            fault_q     <= 1'b1;
            fault_adr_q <= (state == IDLE) ? m_adr_i : s_adr_o;
            fault_to_q  <= (state == ACCESS);
        end else if (fault_clr_i) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_o     = fault_q;
    assign fault_adr_o = fault_adr_q;
    assign fault_to_o  = fault_to_q;
`endif

endmodule

// File: tb/tb_wb_region_router.sv
// tb_wb_region_router
//   Directed bench for wb_region_router. It uses an 8-slot region table and
//   TO_CYCLES = 4. Inputs are driven 1 ns after a rising edge, and outputs are
//   checked at the same point, after the edge has settled. Read data is
//   queued in exp_q when a slave ack is scheduled, and popped when m_ack_o is
//   seen.
module tb_wb_region_router;

    localparam int NSLV = 8;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam logic [NSLV*AW-1:0] BASE = {
        32'h2000_0000, 32'h1FF0_0000, 32'h1FD0_0300, 32'h1FE0_0000,
        32'h1E00_0000, 32'h1FD0_0000, 32'h1FC0_0000, 32'h0000_0000};
    localparam logic [NSLV*AW-1:0] MASK = {
        32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000,
        32'hFF00_0000, 32'hFFFF_0000, 32'hFFF0_0000, 32'hFF80_0000};

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               m_cyc_i = 1'b0;
    logic               m_stb_i = 1'b0;
    logic               m_we_i = 1'b0;
    logic [AW-1:0]      m_adr_i = '0;
    logic [DW/8-1:0]    m_sel_i = '0;
    logic [DW-1:0]      m_dat_i = '0;
    logic [DW-1:0]      m_dat_o;
    logic               m_ack_o;
    logic               m_err_o;
    logic [NSLV-1:0]    s_cyc_o;
    logic [NSLV-1:0]    s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW/8-1:0]    s_sel_o;
    logic [DW-1:0]      s_dat_o;
    logic [NSLV*DW-1:0] s_dat_i = '0;
    logic [NSLV-1:0]    s_ack_i = '0;
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
    logic               fault_clr_i = 1'b0;
    logic               fault_o;
    logic [AW-1:0]      fault_adr_o;
    logic               fault_to_o;
`endif

    int total = 0;
    int bad   = 0;
    int stray = 0;
    logic [NSLV-1:0] allow_stb = '0;
    logic [DW-1:0]   exp_q[$];

    wb_region_router #(
        .NSLV(NSLV), .AW(AW), .DW(DW),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TO_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        ,
        .fault_clr_i(fault_clr_i), .fault_o(fault_o),
        .fault_adr_o(fault_adr_o), .fault_to_o(fault_to_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Background monitor: counts strobes outside the slots the current test
    // allows, cyc/stb disagreement, multi-hot strobes and ack+err together.
    always @(negedge clk) begin
        if (((s_stb_o & ~allow_stb) != '0) || (s_cyc_o != s_stb_o) ||
            !$onehot0(s_stb_o) || (m_ack_o && m_err_o)) begin
            stray++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_adr_i = adr;
        m_dat_i = dat;
        m_sel_i = 4'hF;
    endtask

    task automatic drop();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
    endtask

    task automatic slave_ack(input int idx, input logic [DW-1:0] d, input logic expect_it);
        s_ack_i = '0;
        s_ack_i[idx] = 1'b1;
        s_dat_i[idx*DW +: DW] = d;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic check_ack(input string tag);
        logic [DW-1:0] e;
        chk({tag, "_ack"}, 64'(m_ack_o), 64'd1);
        chk({tag, "_err"}, 64'(m_err_o), 64'd0);
        chk({tag, "_qlen"}, 64'(exp_q.size()), 64'd1);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_dat"}, 64'(m_dat_o), 64'(e));
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_stb", 64'(s_stb_o), 64'd0);
        chk("rst_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        chk("rst_err", 64'(m_err_o), 64'd0);
        chk("rst_mdat", 64'(m_dat_o), 64'd0);
        chk("rst_sadr", 64'(s_adr_o), 64'd0);
        chk("rst_sdat", 64'(s_dat_o), 64'd0);
        chk("rst_ssel", 64'(s_sel_o), 64'd0);
        chk("rst_swe", 64'(s_we_o), 64'd0);
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        chk("rst_fault", 64'(fault_o), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // RAM read hit, ack in second strobe cycle
        allow_stb = 8'h01;
        req(32'h0000_1234, 1'b0, 32'h0);
        tick();
        chk("rd_stb1", 64'(s_stb_o), 64'h01);
        chk("rd_adr", 64'(s_adr_o), 64'h0000_1234);
        chk("rd_noack", 64'(m_ack_o), 64'd0);
        tick();
        chk("rd_stb2", 64'(s_stb_o), 64'h01);
        slave_ack(0, 32'hDEAD_BEEF, 1'b1);
        tick();
        check_ack("rd");
        chk("rd_stb_off", 64'(s_stb_o), 64'd0);
        s_ack_i = '0;
        drop();
        tick();
        chk("rd_ack_once", 64'(m_ack_o), 64'd0);
        chk("rd_dat_hold", 64'(m_dat_o), 64'hDEAD_BEEF);

        // timeout on slot 1: four strobe cycles then error
        allow_stb = 8'h02;
        req(32'h1FC0_0010, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_stb%0d", i), 64'(s_stb_o), 64'h02);
            chk($sformatf("to_noerr%0d", i), 64'(m_err_o), 64'd0);
        end
        tick();
        chk("to_stb_off", 64'(s_stb_o), 64'd0);
        chk("to_err", 64'(m_err_o), 64'd1);
        chk("to_noack", 64'(m_ack_o), 64'd0);
        chk("to_dat0", 64'(m_dat_o), 64'd0);
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        chk("to_fault", 64'(fault_o), 64'd1);
        chk("to_fault_to", 64'(fault_to_o), 64'd1);
        chk("to_fault_adr", 64'(fault_adr_o), 64'h1FC0_0010);
`endif
        drop();
        tick();
        chk("to_err_once", 64'(m_err_o), 64'd0);

        // unmapped write; a clear in the same cycle lets the new fault in
        allow_stb = 8'h00;
        req(32'h3000_0000, 1'b1, 32'hCAFE_0001);
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        fault_clr_i = 1'b1;
`endif
        tick();
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        fault_clr_i = 1'b0;
        chk("um_fault", 64'(fault_o), 64'd1);
        chk("um_fault_to", 64'(fault_to_o), 64'd0);
        chk("um_fault_adr", 64'(fault_adr_o), 64'h3000_0000);
`endif
        chk("um_err", 64'(m_err_o), 64'd1);
        chk("um_noack", 64'(m_ack_o), 64'd0);
        chk("um_stb", 64'(s_stb_o), 64'd0);
        chk("um_we", 64'(s_we_o), 64'd1);
        chk("um_sdat", 64'(s_dat_o), 64'hCAFE_0001);
        drop();
        tick();
        chk("um_err_once", 64'(m_err_o), 64'd0);
`ifdef WB_ROUTER_FAULT_CAPTURE_EN
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
        chk("clr_fault", 64'(fault_o), 64'd0);
`endif

        // overlap: slots 2 and 5 both match, slot 2 wins; slot 5 ack ignored
        allow_stb = 8'h04;
        req(32'h1FD0_03F8, 1'b0, 32'h0);
        tick();
        chk("ov_stb", 64'(s_stb_o), 64'h04);
        slave_ack(5, 32'h5555_5555, 1'b0);
        tick();
        chk("ov_ign_ack", 64'(m_ack_o), 64'd0);
        chk("ov_stb_hold", 64'(s_stb_o), 64'h04);
        slave_ack(2, 32'h2222_2222, 1'b1);
        s_ack_i[5] = 1'b1;
        tick();
        check_ack("ov");
        s_ack_i = '0;
        drop();
        tick();

        // master abort during ACCESS, then a normal read
        allow_stb = 8'h09;
        req(32'h0000_0040, 1'b0, 32'h0);
        tick();
        chk("ab_stb", 64'(s_stb_o), 64'h01);
        drop();
        tick();
        chk("ab_stb_off", 64'(s_stb_o), 64'd0);
        chk("ab_noack", 64'(m_ack_o), 64'd0);
        chk("ab_noerr", 64'(m_err_o), 64'd0);
        tick();
        chk("ab_noack2", 64'(m_ack_o), 64'd0);
        chk("ab_noerr2", 64'(m_err_o), 64'd0);
        req(32'h1E00_0040, 1'b0, 32'h0);
        tick();
        chk("ab_next_stb", 64'(s_stb_o), 64'h08);
        slave_ack(3, 32'h3333_0003, 1'b1);
        tick();
        check_ack("ab_next");
        s_ack_i = '0;
        drop();
        tick();

        // reset during ACCESS, then a normal read
        allow_stb = 8'h50;
        req(32'h1FF0_0004, 1'b0, 32'h0);
        tick();
        chk("rs_stb", 64'(s_stb_o), 64'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drop();
        chk("rs_stb_off", 64'(s_stb_o), 64'd0);
        chk("rs_noack", 64'(m_ack_o), 64'd0);
        chk("rs_noerr", 64'(m_err_o), 64'd0);
        chk("rs_dat0", 64'(m_dat_o), 64'd0);
        tick();
        chk("rs_noack2", 64'(m_ack_o), 64'd0);
        chk("rs_noerr2", 64'(m_err_o), 64'd0);
        req(32'h1FE0_0008, 1'b0, 32'h0);
        tick();
        chk("rs_next_stb", 64'(s_stb_o), 64'h10);
        slave_ack(4, 32'h4444_0004, 1'b1);
        tick();
        check_ack("rs_next");
        s_ack_i = '0;
        drop();
        tick();

        // back-to-back reads with stb held across the ack
        allow_stb = 8'h81;
        req(32'h0000_0100, 1'b0, 32'h0);
        tick();
        chk("bb_stb1", 64'(s_stb_o), 64'h01);
        slave_ack(0, 32'hA5A5_0001, 1'b1);
        tick();
        check_ack("bb1");
        s_ack_i = '0;
        m_adr_i = 32'h2000_0010;
        tick();
        chk("bb_gap_stb", 64'(s_stb_o), 64'd0);
        chk("bb_gap_ack", 64'(m_ack_o), 64'd0);
        tick();
        chk("bb_stb2", 64'(s_stb_o), 64'h80);
        slave_ack(7, 32'h5A5A_0007, 1'b1);
        tick();
        check_ack("bb2");
        s_ack_i = '0;
        drop();
        tick();

        // final report
        chk("monitor", 64'(stray), 64'd0);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
